// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: synchronises sclk/mosi/cs_n into clk, deserialises MSB-first words
// into a first-word-fall-through FIFO. Optional macro SPI_SLAVE_RX_BYTE_CNT_EN adds frame_word_cnt.
module spi_slave_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  input  logic                  cpol,
  input  logic                  cpha,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overflow,
  input  logic                  ovf_clr,
  output logic                  frame_err,
  output logic                  busy
`ifdef SPI_SLAVE_RX_BYTE_CNT_EN
  ,
  output logic [15:0]           frame_word_cnt
`endif
);

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_next;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_n_p0, cs_n_p1, cs_n_p2;
  logic mosi_p0, mosi_p1;
  logic [1:0] prime_cnt;
  logic primed;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, sample_edge;
  logic cpol_lat, cpha_lat;
  logic frame_start, frame_end, shift_en, word_done, partial_abort;

  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] word;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic push, pop, full, push_ok;

  // ---- stage p0/p1: 2-FF synchronisers; p2: edge-detect history ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      cs_n_p0 <= 1'b1;
      cs_n_p1 <= 1'b1;
      cs_n_p2 <= 1'b1;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
      cs_n_p0 <= cs_n;
      cs_n_p1 <= cs_n_p0;
      cs_n_p2 <= cs_n_p1;
    end
  end

  // The cs_n chain resets to 1, so it only reflects the pin after two clocks;
  // leaving WAIT_IDLE earlier would let us join a frame already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prime_cnt <= 2'd0;
    else if (!prime_cnt[1])
      prime_cnt <= prime_cnt + 2'd1;
  end

  assign primed      = prime_cnt[1];
  assign sclk_rise   =  sclk_p1 & ~sclk_p2;
  assign sclk_fall   = ~sclk_p1 &  sclk_p2;
  assign cs_fall     = ~cs_n_p1 &  cs_n_p2;
  assign cs_rise     =  cs_n_p1 & ~cs_n_p2;
  assign sample_edge = (cpol_lat ^ cpha_lat) ? sclk_fall : sclk_rise;
  assign word        = {shift_reg[DATA_WIDTH-2:0], mosi_p1};

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= WAIT_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (primed && cs_n_p1) state_next = IDLE;
      IDLE:      if (cs_fall)           state_next = ACTIVE;
      ACTIVE:    if (cs_rise)           state_next = IDLE;
      default:                          state_next = WAIT_IDLE;
    endcase
  end

  // cs_n rise takes priority over a coincident sample edge.
  always_comb begin
    busy          = (state == ACTIVE);
    frame_start   = (state == IDLE) && cs_fall;
    frame_end     = (state == ACTIVE) && cs_rise;
    shift_en      = (state == ACTIVE) && !cs_rise && sample_edge;
    word_done     = shift_en && (bit_cnt == LAST_BIT);
    partial_abort = frame_end && (bit_cnt != '0);
  end

  // ---- deserialiser ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_lat  <= 1'b0;
      cpha_lat  <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= partial_abort;
      if (frame_start) begin
        cpol_lat <= cpol;
        cpha_lat <= cpha;
        bit_cnt  <= '0;
      end else if (frame_end) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_reg <= word;
        bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // ---- receive FIFO ----
  assign push    = word_done;
  assign pop     = rx_valid && rx_ready;
  assign full    = (count == FULL_CNT);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop)
        rx_overflow <= 1'b1;
      else if (ovf_clr)
        rx_overflow <= 1'b0;
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

`ifdef SPI_SLAVE_RX_BYTE_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counts push attempts, so dropped words are included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_word_cnt <= 16'd0;
    else if (frame_start)
      frame_word_cnt <= 16'd0;
    else if (word_done)
      frame_word_cnt <= sat_inc16(frame_word_cnt);
  end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: an SPI master task drives frames, a queue model of the
// receive FIFO predicts every popped word, overflow and frame error.
module tb_spi_slave_rx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n, sclk, mosi, cs_n, cpol, cpha;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_overflow, ovf_clr, frame_err, busy;
`ifdef SPI_SLAVE_RX_BYTE_CNT_EN
  logic [15:0] frame_word_cnt;
`endif

  spi_slave_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .cpol(cpol), .cpha(cpha), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overflow(rx_overflow), .ovf_clr(ovf_clr),
    .frame_err(frame_err), .busy(busy)
`ifdef SPI_SLAVE_RX_BYTE_CNT_EN
    , .frame_word_cnt(frame_word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];
  logic       model_ovf;
  logic [7:0] wbuf [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of the receive FIFO as seen by the consumer: bounded queue of words.
  task automatic model_push(input logic [7:0] w);
    if (exp_q.size() < 16) exp_q.push_back(w);
    else model_ovf = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_err) ferr_cnt++;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(rx_valid), 32'd0);
      else chk("rx_word", 32'(rx_data), 32'(exp_q.pop_front()));
      pop_cnt++;
    end
  end

  // mode = {cpol, cpha}; sends nwords full words from wbuf then tail_bits of wbuf[nwords].
  task automatic spi_frame(input int mode, input int nwords, input int tail_bits);
    int total, nb;
    logic ch;
    ch    = mode[0];
    cpol  = mode[1];
    cpha  = ch;
    sclk  = mode[1];
    total = nwords + ((tail_bits > 0) ? 1 : 0);
    #(HALF);
    cs_n = 1'b0;
    #(HALF);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int w = 0; w < total; w++) begin
      nb = (w < nwords) ? 8 : tail_bits;
      if (w < nwords) model_push(wbuf[w]);
      for (int b = 0; b < nb; b++) begin
        if (!ch) begin
          mosi = wbuf[w][7-b];
          #(HALF); sclk = ~sclk;
          #(HALF); sclk = ~sclk;
        end else begin
          sclk = ~sclk; mosi = wbuf[w][7-b];
          #(HALF); sclk = ~sclk;
          #(HALF);
        end
      end
    end
    #(HALF);
    cs_n = 1'b1;
    #(2*HALF);
    chk("busy_after_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    int p0, f0, mode, n;
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; cpol = 1'b0; cpha = 1'b0;
    rx_ready = 1'b1; ovf_clr = 1'b0; model_ovf = 1'b0;
    #28;
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_overflow", 32'(rx_overflow), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #100;

    // Mode 0 single word
    p0 = pop_cnt; f0 = ferr_cnt;
    wbuf[0] = 8'hA5;
    spi_frame(0, 1, 0);
    chk("a5_beats", 32'(pop_cnt - p0), 32'd1);
    chk("a5_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Two words under one cs_n, every mode
    for (int m = 0; m < 4; m++) begin
      p0 = pop_cnt;
      wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
      spi_frame(m, 2, 0);
      chk("two_word_beats", 32'(pop_cnt - p0), 32'd2);
    end

    // Random frames
    for (int k = 0; k < 6; k++) begin
      mode = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      p0 = pop_cnt;
      spi_frame(mode, n, 0);
      chk("rand_beats", 32'(pop_cnt - p0), 32'(n));
    end

    // Overflow: 17 words with the consumer stalled
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) wbuf[i] = 8'($urandom);
    spi_frame(int'($urandom_range(0, 3)), 17, 0);
    chk("ovf_set", 32'(rx_overflow), 32'(model_ovf));
    chk("ovf_head_valid", 32'(rx_valid), 32'd1);
    chk("ovf_head_stable", 32'(rx_data), 32'(wbuf[0]));
    ovf_clr = 1'b1; #10; ovf_clr = 1'b0; model_ovf = 1'b0; #10;
    chk("ovf_cleared", 32'(rx_overflow), 32'(model_ovf));
    p0 = pop_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) #10;
    #20;
    chk("drain_count", 32'(pop_cnt - p0), 32'd16);
    chk("drain_empty", 32'(rx_valid), 32'd0);

    // Partial frame then a clean one
    p0 = pop_cnt; f0 = ferr_cnt;
    wbuf[0] = 8'hFF;
    spi_frame(0, 0, 5);
    chk("partial_ferr_cycles", 32'(ferr_cnt - f0), 32'd1);
    chk("partial_no_push", 32'(pop_cnt - p0), 32'd0);
    wbuf[0] = 8'h81;
    spi_frame(int'($urandom_range(0, 3)), 1, 0);
    chk("after_partial_beats", 32'(pop_cnt - p0), 32'd1);

    // Reset asserted and released mid-frame with sclk toggling
    p0 = pop_cnt; f0 = ferr_cnt;
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    cs_n = 1'b0;
    for (int i = 0; i < 4; i++) begin mosi = 1'($urandom); #(HALF); sclk = ~sclk; end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    #9;
    for (int i = 0; i < 4; i++) begin mosi = 1'($urandom); #(HALF); sclk = ~sclk; end
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin mosi = 1'($urandom); #(HALF); sclk = ~sclk; end
    chk("joined_busy", 32'(busy), 32'd0);
    chk("joined_no_push", 32'(pop_cnt - p0), 32'd0);
    chk("joined_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    cs_n = 1'b1;
    #(2*HALF);
    wbuf[0] = 8'h5A;
    spi_frame(0, 1, 0);
    chk("after_rst_beats", 32'(pop_cnt - p0), 32'd1);

`ifdef SPI_SLAVE_RX_BYTE_CNT_EN
    for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
    spi_frame(int'($urandom_range(0, 3)), 3, 0);
    chk("word_cnt_hold", 32'(frame_word_cnt), 32'd3);
    cs_n = 1'b0;
    #50;
    chk("word_cnt_clear", 32'(frame_word_cnt), 32'd0);
    cs_n = 1'b1;
    #(2*HALF);
`endif

    chk("model_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
